// File: rtl/fpmul_pkg.sv
// Shared constants, override-tag type and operand classification for the
// flow-control wrapper around the FP32 multiplier pipeline.
package fpmul_pkg;

    localparam int unsigned BIAS           = 127;
    localparam logic [31:0] QNAN           = 32'h7FC0_0000;
    localparam logic [31:0] INF            = 32'h7F80_0000;
    localparam logic [7:0]  EXP_MAX        = 8'd255;
    localparam int unsigned FLAG_INVALID   = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    typedef struct packed {
        logic        valid;
        logic        ovr_en;
        logic [31:0] ovr_val;
        logic [2:0]  flags;
    } tag_t;

    // Range check ignores the normalisation shift, so it is deliberately conservative.
    function automatic tag_t classify(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic              za;
        logic              zb;
        logic              ia;
        logic              ib;
        logic              na;
        logic              nb;
        logic              s;
        logic signed [9:0] esum;
        tag_t              t;
        ea   = a[30:23];
        eb   = b[30:23];
        za   = (ea == '0);
        zb   = (eb == '0);
        ia   = (ea == EXP_MAX) && (a[22:0] == '0);
        ib   = (eb == EXP_MAX) && (b[22:0] == '0);
        na   = (ea == EXP_MAX) && (a[22:0] != '0);
        nb   = (eb == EXP_MAX) && (b[22:0] != '0);
        s    = a[31] ^ b[31];
        esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
        t    = '0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            t.ovr_en              = 1'b1;
            t.ovr_val             = QNAN;
            t.flags[FLAG_INVALID] = 1'b1;
        end else if (ia || ib) begin
            t.ovr_en  = 1'b1;
            t.ovr_val = {s, INF[30:0]};
        end else if (za || zb) begin
            t.ovr_en  = 1'b1;
            t.ovr_val = {s, 31'b0};
        end else if (esum >= 10'sd254) begin
            t.ovr_en               = 1'b1;
            t.ovr_val              = {s, INF[30:0]};
            t.flags[FLAG_OVERFLOW] = 1'b1;
        end else if (esum <= 10'sd0) begin
            t.ovr_en                = 1'b1;
            t.ovr_val               = {s, 31'b0};
            t.flags[FLAG_UNDERFLOW] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/fpmul_result_fifo.sv
// Synchronous result FIFO with wrapping pointers and an occupancy count.
module fpmul_result_fifo
    import fpmul_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpmul_ctrl.sv
// Valid/ready and exception wrapper for the free-running FP32 multiplier:
// issues operands, tags each cycle, captures results into a credit-limited FIFO.
module fpmul_ctrl
    import fpmul_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_f,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt;
    logic          accept;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [34:0]   fifo_wdata;
    logic [34:0]   fifo_rdata;
    tag_t          tag_in;
    tag_t          tail;
    tag_t          pipe [MUL_LAT];

    assign mul_a    = in_a;
    assign mul_b    = in_b;
    assign in_ready = (cnt < CW'(DEPTH));
    assign accept   = in_valid && in_ready;

    always_comb begin
        tag_in       = classify(in_a, in_b);
        tag_in.valid = accept;
    end

    // Tag line runs in lockstep with the multiplier stages; the tail lines up with mul_f.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail       = pipe[MUL_LAT-1];
    assign push       = tail.valid;
    assign fifo_wdata = {(tail.ovr_en ? tail.ovr_val : mul_f), tail.flags};

    fpmul_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (35)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push),
        .wr_data (fifo_wdata),
        .pop     (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[34:3];
    assign out_flags = fifo_empty ? '0 : fifo_rdata[2:0];

    // Credits cover in-flight tags plus FIFO occupancy, so a full FIFO has nothing in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !accept) begin
            cnt <= cnt - 1'b1;
        end
    end

    a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule
